// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline types: EX/MEM control bundle, writeback-source encodings
// and the full EX/MEM payload carried through the skid buffer.
package riscv_pkg;

  localparam int XLEN  = 32;
  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    M2R_ALU = 2'b00,
    M2R_MEM = 2'b01,
    M2R_PC4 = 2'b10
  } mem_to_reg_e;

  typedef struct packed {
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    mem_to_reg_e mem_to_reg;
  } ctrl_t;

  // Field widths are fixed here, so the top-level width parameters must stay at XLEN/REG_W.
  typedef struct packed {
    logic [XLEN-1:0]  alu_result;
    logic [XLEN-1:0]  store_data;
    logic [XLEN-1:0]  pc_plus4;
    logic [REG_W-1:0] rd;
    logic [2:0]       funct3;
    ctrl_t            ctrl;
  } ex_mem_t;

endpackage

// File: rtl/skid_buffer.sv
// Generic 2-entry valid/ready skid buffer with synchronous flush.
// in_ready comes straight from a flop, so there is no combinational out_ready -> in_ready path.
module skid_buffer #(
  parameter type T = logic [7:0]
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);

  logic m_valid;
  logic s_valid;
  T     m_data;
  T     s_data;
  logic in_xfer;
  logic out_xfer;

  assign in_ready  = !s_valid;
  assign out_valid = m_valid;
  assign out_data  = m_data;
  assign in_xfer   = in_valid && !s_valid;
  assign out_xfer  = m_valid && out_ready;

  // M is the head; S only fills when M is held by a stalled consumer and another entry arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      m_data  <= '0;
      s_data  <= '0;
    end else if (flush) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (!m_valid) begin
      if (in_xfer) begin
        m_data  <= in_data;
        m_valid <= 1'b1;
      end
    end else if (!s_valid) begin
      if (out_xfer) begin
        if (in_xfer) begin
          m_data <= in_data;
        end else begin
          m_valid <= 1'b0;
        end
      end else if (in_xfer) begin
        s_data  <= in_data;
        s_valid <= 1'b1;
      end
    end else if (out_xfer) begin
      m_data  <= s_data;
      s_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ex_mem_skid.sv
// EX/MEM pipeline boundary: skid-buffered handshake between execute and memory
// stages, plus the EX/MEM forwarding view consumed by the hazard unit.
module ex_mem_skid
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH = XLEN,
  parameter int REG_ADDR_W = REG_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_alu_result,
  input  logic [DATA_WIDTH-1:0] in_store_data,
  input  logic [DATA_WIDTH-1:0] in_pc_plus4,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic [2:0]            in_funct3,
  input  ctrl_t                 in_ctrl,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_alu_result,
  output logic [DATA_WIDTH-1:0] out_store_data,
  output logic [DATA_WIDTH-1:0] out_pc_plus4,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic [2:0]            out_funct3,
  output ctrl_t                 out_ctrl,
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_rd,
  output logic [DATA_WIDTH-1:0] fwd_data,
  output logic                  fwd_is_load
);

  ex_mem_t in_entry;
  ex_mem_t head;

  always_comb begin
    in_entry            = '0;
    in_entry.alu_result = in_alu_result;
    in_entry.store_data = in_store_data;
    in_entry.pc_plus4   = in_pc_plus4;
    in_entry.rd         = in_rd;
    in_entry.funct3     = in_funct3;
    in_entry.ctrl       = in_ctrl;
  end

  skid_buffer #(
    .T(ex_mem_t)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_entry),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (head)
  );

  assign out_alu_result = head.alu_result;
  assign out_store_data = head.store_data;
  assign out_pc_plus4   = head.pc_plus4;
  assign out_rd         = head.rd;
  assign out_funct3     = head.funct3;
  assign out_ctrl       = head.ctrl;

  // x0 is never a forwarding source; loads are flagged so the hazard unit stalls instead.
  assign fwd_valid   = out_valid && head.ctrl.reg_write && (head.rd != '0);
  assign fwd_rd      = head.rd;
  assign fwd_data    = (head.ctrl.mem_to_reg == M2R_PC4) ? head.pc_plus4 : head.alu_result;
  assign fwd_is_load = out_valid && head.ctrl.mem_read;

endmodule

// File: tb/tb_ex_mem_skid.sv
// Scoreboard bench for ex_mem_skid: the driver queues every accepted entry, the
// monitor pops and compares whenever MEM consumes one.
module tb_ex_mem_skid;
  import riscv_pkg::*;

  logic    clk = 1'b0;
  logic    rst_n = 1'b0;
  logic    flush = 1'b0;
  logic    in_valid = 1'b0;
  logic    out_ready = 1'b0;
  ex_mem_t in_p = '0;

  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_alu_result;
  logic [31:0] out_store_data;
  logic [31:0] out_pc_plus4;
  logic [4:0]  out_rd;
  logic [2:0]  out_funct3;
  ctrl_t       out_ctrl;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
  logic        fwd_is_load;

  int      checks = 0;
  int      errors = 0;
  ex_mem_t exp_q[$];
  ex_mem_t mon_exp;
  ex_mem_t mon_cur;
  ex_mem_t mon_held;
  logic    mon_held_valid = 1'b0;

  ex_mem_skid dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_alu_result (in_p.alu_result),
    .in_store_data (in_p.store_data),
    .in_pc_plus4   (in_p.pc_plus4),
    .in_rd         (in_p.rd),
    .in_funct3     (in_p.funct3),
    .in_ctrl       (in_p.ctrl),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_alu_result(out_alu_result),
    .out_store_data(out_store_data),
    .out_pc_plus4  (out_pc_plus4),
    .out_rd        (out_rd),
    .out_funct3    (out_funct3),
    .out_ctrl      (out_ctrl),
    .fwd_valid     (fwd_valid),
    .fwd_rd        (fwd_rd),
    .fwd_data      (fwd_data),
    .fwd_is_load   (fwd_is_load)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  function automatic ex_mem_t mk(input logic [31:0] alu, input logic [4:0] rd,
                                 input logic rw, input logic mr, input logic mw,
                                 input mem_to_reg_e m2r, input logic [31:0] pc4,
                                 input logic [31:0] sd, input logic [2:0] f3);
    ex_mem_t e;
    e.alu_result      = alu;
    e.store_data      = sd;
    e.pc_plus4        = pc4;
    e.rd              = rd;
    e.funct3          = f3;
    e.ctrl.reg_write  = rw;
    e.ctrl.mem_read   = mr;
    e.ctrl.mem_write  = mw;
    e.ctrl.mem_to_reg = m2r;
    return e;
  endfunction

  // One clock of stimulus: drive just after the rising edge, decide acceptance at the falling edge.
  task automatic apply_stimulus(input logic v, input ex_mem_t p, input logic ordy,
                                input logic fl, output logic accepted);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_p      = p;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
    accepted = v && in_ready && !fl;
    if (fl) exp_q.delete();
    else if (accepted) exp_q.push_back(p);
  endtask

  initial begin
    fork
      begin : driver
        logic    acc;
        int      idx;
        ex_mem_t p;
        ex_mem_t bp [6];

        #3;
        check_output("reset_out_valid", out_valid, 0);
        check_output("reset_fwd_valid", fwd_valid, 0);
        check_output("reset_alu", out_alu_result, 0);
        check_output("reset_fwd_data", fwd_data, 0);
        check_output("reset_rd", out_rd, 0);
        #9;
        rst_n = 1'b1;
        #1;
        check_output("reset_in_ready", in_ready, 1);

        p = mk(32'h0000_0010, 5'd5, 1, 0, 0, M2R_ALU, 32'h0, 32'h0, 3'b010);
        apply_stimulus(1, p, 1, 0, acc);
        check_output("single_accept", acc, 1);
        apply_stimulus(0, '0, 1, 0, acc);
        check_output("single_out_valid", out_valid, 1);
        check_output("single_fwd_valid", fwd_valid, 1);
        check_output("single_fwd_rd", fwd_rd, 5);
        check_output("single_fwd_data", fwd_data, 32'h10);
        apply_stimulus(0, '0, 1, 0, acc);
        check_output("single_drained", out_valid, 0);

        for (int i = 0; i < 6; i++)
          bp[i] = mk(32'(i + 1), 5'(i + 1), 1, 0, 0, M2R_ALU, 32'(i + 101), 32'(i + 201), 3'b000);
        idx = 0;
        for (int c = 0; c < 12; c++) begin
          apply_stimulus(idx < 6, (idx < 6) ? bp[idx] : ex_mem_t'('0), !(c >= 2 && c <= 4), 0, acc);
          check_output($sformatf("bp_in_ready_c%0d", c), in_ready, (c >= 3 && c <= 5) ? 0 : 1);
          if (acc) idx++;
        end
        check_output("bp_all_accepted", idx, 6);

        apply_stimulus(1, mk(32'hA, 1, 1, 0, 0, M2R_ALU, 0, 0, 0), 0, 0, acc);
        apply_stimulus(1, mk(32'hB, 2, 1, 0, 0, M2R_ALU, 0, 0, 0), 0, 0, acc);
        check_output("flush_s_filled", acc, 1);
        apply_stimulus(1, mk(32'hC, 3, 1, 0, 0, M2R_ALU, 0, 0, 0), 0, 1, acc);
        apply_stimulus(0, '0, 1, 0, acc);
        check_output("flush_full_out_valid", out_valid, 0);
        check_output("flush_full_in_ready", in_ready, 1);

        apply_stimulus(1, mk(32'hD, 4, 1, 0, 0, M2R_ALU, 0, 0, 0), 0, 0, acc);
        apply_stimulus(1, mk(32'hE, 5, 1, 0, 0, M2R_ALU, 0, 0, 0), 0, 1, acc);
        apply_stimulus(1, mk(32'hF, 6, 1, 0, 0, M2R_ALU, 0, 0, 0), 1, 0, acc);
        check_output("flush_half_out_valid", out_valid, 0);
        check_output("flush_half_in_ready", in_ready, 1);
        apply_stimulus(0, '0, 1, 0, acc);

        apply_stimulus(1, mk(32'h55, 0, 1, 0, 0, M2R_ALU, 32'h4, 0, 0), 0, 0, acc);
        apply_stimulus(0, '0, 0, 0, acc);
        check_output("rd0_out_valid", out_valid, 1);
        check_output("rd0_fwd_valid", fwd_valid, 0);
        apply_stimulus(0, '0, 1, 0, acc);
        apply_stimulus(1, mk(32'hDEAD, 1, 1, 0, 0, M2R_PC4, 32'h104, 0, 0), 0, 0, acc);
        apply_stimulus(0, '0, 0, 0, acc);
        check_output("pc4_fwd_data", fwd_data, 32'h104);
        check_output("pc4_fwd_valid", fwd_valid, 1);
        apply_stimulus(0, '0, 1, 0, acc);
        apply_stimulus(1, mk(32'h2000, 7, 1, 1, 0, M2R_MEM, 32'h8, 0, 3'b100), 0, 0, acc);
        apply_stimulus(0, '0, 0, 0, acc);
        check_output("load_fwd_is_load", fwd_is_load, 1);
        check_output("load_fwd_data", fwd_data, 32'h2000);
        apply_stimulus(0, '0, 1, 0, acc);

        apply_stimulus(1, mk(32'h77, 8, 1, 0, 0, M2R_ALU, 0, 0, 0), 0, 0, acc);
        apply_stimulus(1, mk(32'h88, 9, 1, 0, 0, M2R_ALU, 0, 0, 0), 0, 0, acc);
        apply_stimulus(0, '0, 0, 0, acc);
        check_output("stall_full_in_ready", in_ready, 0);
        check_output("stall_full_out_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check_output("async_rst_out_valid", out_valid, 0);
        check_output("async_rst_in_ready", in_ready, 1);
        check_output("async_rst_alu", out_alu_result, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        apply_stimulus(1, mk(32'h99, 10, 1, 0, 0, M2R_ALU, 0, 0, 0), 1, 0, acc);
        check_output("post_rst_accept", acc, 1);
        apply_stimulus(0, '0, 1, 0, acc);

        for (int i = 0; i < 100; i++) begin
          p = mk($urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 mem_to_reg_e'(2'($urandom_range(0, 2))), $urandom, $urandom,
                 3'($urandom_range(0, 7)));
          apply_stimulus(1, p, 1, 0, acc);
          check_output("stream_accept", acc, 1);
          if (i > 0) check_output("stream_out_valid", out_valid, 1);
        end
        for (int i = 0; i < 3; i++) apply_stimulus(0, '0, 1, 0, acc);
        check_output("queue_drained", exp_q.size(), 0);
      end

      begin : monitor
        forever begin
          @(negedge clk);
          if (!rst_n) begin
            mon_held_valid = 1'b0;
          end else begin
            mon_cur = mk(out_alu_result, out_rd, out_ctrl.reg_write, out_ctrl.mem_read,
                         out_ctrl.mem_write, out_ctrl.mem_to_reg, out_pc_plus4,
                         out_store_data, out_funct3);
            if (!in_ready && !out_valid) check_output("legal_state", 0, 1);
            if (out_valid && !out_ready) begin
              if (mon_held_valid) check_output("stall_stable", mon_cur, mon_held);
              mon_held       = mon_cur;
              mon_held_valid = 1'b1;
            end else begin
              mon_held_valid = 1'b0;
            end
            if (out_valid && out_ready) begin
              if (exp_q.size() == 0) begin
                check_output("unexpected_output", 1, 0);
              end else begin
                mon_exp = exp_q.pop_front();
                check_output("out_alu_result", out_alu_result, mon_exp.alu_result);
                check_output("out_store_data", out_store_data, mon_exp.store_data);
                check_output("out_pc_plus4", out_pc_plus4, mon_exp.pc_plus4);
                check_output("out_rd", out_rd, mon_exp.rd);
                check_output("out_funct3", out_funct3, mon_exp.funct3);
                check_output("out_ctrl", out_ctrl, mon_exp.ctrl);
                check_output("fwd_rd", fwd_rd, mon_exp.rd);
                check_output("fwd_valid", fwd_valid,
                             mon_exp.ctrl.reg_write && (mon_exp.rd != 0));
                check_output("fwd_data", fwd_data,
                             (mon_exp.ctrl.mem_to_reg == M2R_PC4) ? mon_exp.pc_plus4
                                                                  : mon_exp.alu_result);
                check_output("fwd_is_load", fwd_is_load, mon_exp.ctrl.mem_read);
              end
            end
          end
        end
      end

      begin : watchdog
        #100000;
        check_output("timeout", 1, 0);
      end
    join_any
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
